// File: rtl/wb_initiator_if.sv
// Command/response stream and Wishbone master bus bundle for wb_initiator.
// The master modport is the initiator's view; slave is the view of whatever
// drives commands, consumes responses and responds on the bus.
interface wb_initiator_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  // command stream
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [SEL_W-1:0]  cmd_we_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;

  // response stream
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic [7:0]        err_count_o;

  // Wishbone pipelined master
  logic              m_cyc_o;
  logic              m_stb_o;
  logic [SEL_W-1:0]  m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_stall_i;
  logic              m_ack_i;
  logic [DATA_W-1:0] m_data_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i,
    input  rsp_ready_i,
    input  m_stall_i, m_ack_i, m_data_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, err_count_o,
    output m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i,
    output rsp_ready_i,
    output m_stall_i, m_ack_i, m_data_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, err_count_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus
// transaction (bounded by a timeout), one response out.
module wb_initiator #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16   // legal 2..255
) (
  input logic clk,
  input logic RST_N,
  wb_initiator_if.master bus
);
  localparam int unsigned SEL_W = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  logic [SEL_W-1:0]  lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [7:0]        err_count;
  logic              cmd_ready;
  logic              rsp_valid;
  logic              cyc;
  logic              stb;
  logic [SEL_W-1:0]  we_out;

  logic done_ok;
  logic timed_out;

  // A qualifying ack: accepted-with-ack in REQ, or any ack in WAIT. Ack
  // beats the timeout on the same edge.
  always_comb begin
    done_ok   = ((state == REQ) && !bus.m_stall_i && bus.m_ack_i) ||
                ((state == WAIT) && bus.m_ack_i);
    timed_out = ((state == REQ) || (state == WAIT)) && !done_ok &&
                (cnt == CNT_LAST);
  end

  // Transaction FSM with registered bus and stream outputs.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      lat_we    <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we_out    <= '0;
    end else if (done_ok || timed_out) begin
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we_out    <= '0;
      rsp_valid <= 1'b1;
      state     <= RESP;
      if (done_ok) begin
        rsp_data <= bus.m_data_i;
        rsp_err  <= 1'b0;
      end else begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            lat_we    <= bus.cmd_we_i;
            lat_addr  <= bus.cmd_addr_i;
            lat_data  <= bus.cmd_data_i;
            we_out    <= bus.cmd_we_i;
            cnt       <= '0;
            cyc       <= 1'b1;
            stb       <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (!bus.m_stall_i) begin
            stb   <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.err_count_o = err_count;
  assign bus.m_cyc_o     = cyc;
  assign bus.m_stb_o     = stb;
  assign bus.m_we_o      = we_out;
  assign bus.m_addr_o    = lat_addr;
  assign bus.m_data_o    = lat_data;

  // Keeps the latched enables meaningful even though the bus copy is cleared.
  logic unused_we;
  assign unused_we = ^lat_we;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator: the bench plays command source, response
// sink and a memory-backed Wishbone responder with scripted stall/ack timing.
module tb_wb_initiator;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int unsigned   exp_errs;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = '0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.m_stall_i   = 1'b0;
    bus.m_ack_i     = 1'b0;
    bus.m_data_i    = $urandom;
  endtask

  // One full transaction. The responder stalls stall_n stb cycles, accepts,
  // then acks ack_dly cycles after acceptance (0 = ack with acceptance), or
  // never if noack. Expectations follow from the timing rules alone.
  task automatic run_txn(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] data,
                         input int unsigned stall_n, input int unsigned ack_dly,
                         input bit noack, input int unsigned hold);
    logic [31:0] old;
    logic [31:0] exp_rsp;
    int unsigned ack_cycle, exp_cyc, exp_stb;
    bit          exp_err, accepted;
    int unsigned k, got_k, stb_seen, acc_k, bad, cyc_cnt, stb_cnt;

    old       = mem[addr];
    ack_cycle = stall_n + 1 + ack_dly;
    exp_err   = noack || (ack_cycle > TO);
    exp_cyc   = exp_err ? TO : ack_cycle;
    exp_stb   = (stall_n + 1 > TO) ? TO : stall_n + 1;
    exp_rsp   = exp_err ? 32'h0 : old;
    if (exp_err && exp_errs < 255) exp_errs++;

    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    check("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 4'($urandom);
    bus.cmd_addr_i  = 11'($urandom);
    bus.cmd_data_i  = $urandom;

    k = 1; got_k = 0; stb_seen = 0; acc_k = 0; accepted = 0;
    bad = 0; cyc_cnt = 0; stb_cnt = 0;
    while (k <= TO + 4) begin
      if (bus.rsp_valid_o) begin
        got_k = k;
        break;
      end
      if (bus.m_cyc_o) cyc_cnt++;
      if (bus.m_cyc_o && bus.m_we_o !== we) bad++;
      if (bus.cmd_ready_o) bad++;
      bus.m_ack_i   = 1'b0;
      bus.m_stall_i = 1'b0;
      bus.m_data_i  = $urandom;
      if (bus.m_stb_o) begin
        stb_cnt++;
        if (bus.m_addr_o !== addr || bus.m_data_o !== data) bad++;
        if (stb_seen < stall_n) begin
          bus.m_stall_i = 1'b1;
          bus.m_ack_i   = 1'($urandom_range(0, 1));
        end else begin
          accepted = 1;
          acc_k    = k;
          for (int b = 0; b < SW; b++)
            if (we[b]) mem[addr][8*b +: 8] = data[8*b +: 8];
          if (!noack && ack_dly == 0) begin
            bus.m_ack_i  = 1'b1;
            bus.m_data_i = old;
          end
        end
        stb_seen++;
      end else if (bus.m_cyc_o && accepted && !noack && k == acc_k + ack_dly) begin
        bus.m_ack_i  = 1'b1;
        bus.m_data_i = old;
      end
      @(negedge clk);
      k++;
    end
    bus.m_ack_i   = 1'b0;
    bus.m_stall_i = 1'b0;

    check("rsp_valid_arrives", 32'(bus.rsp_valid_o), 32'd1);
    check("rsp_latency", got_k, exp_cyc + 1);
    check("cyc_cycles", cyc_cnt, exp_cyc);
    check("stb_cycles", stb_cnt, exp_stb);
    check("req_stable", bad, 32'd0);
    check("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
    check("rsp_data", bus.rsp_data_o, exp_rsp);
    check("err_count", 32'(bus.err_count_o), exp_errs);
    check("cyc_low_in_resp", 32'(bus.m_cyc_o), 32'd0);
    check("we_zero_in_resp", 32'(bus.m_we_o), 32'd0);

    for (int unsigned h = 0; h < hold; h++) begin
      bus.m_ack_i  = 1'($urandom_range(0, 1));
      bus.m_data_i = $urandom;
      @(negedge clk);
      check("rsp_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("rsp_hold_data", bus.rsp_data_o, exp_rsp);
    end
    bus.m_ack_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.m_ack_i     = 1'($urandom_range(0, 1));
    check("rsp_valid_drop", 32'(bus.rsp_valid_o), 32'd0);
    check("cmd_ready_back", 32'(bus.cmd_ready_o), 32'd1);
    check("addr_latched", 32'(bus.m_addr_o), 32'(addr));
    check("data_latched", bus.m_data_o, data);
    check("rsp_data_kept", bus.rsp_data_o, exp_rsp);
    bus.m_ack_i = 1'b0;
  endtask

  // Reset arrives while waiting for an ack that never comes.
  task automatic reset_mid_txn();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 4'h0;
    bus.cmd_addr_i  = 11'h00F;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("cyc_before_reset", 32'(bus.m_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_errs = 0;
    check("rst_cyc_drop", 32'(bus.m_cyc_o), 32'd0);
    check("rst_stb_drop", 32'(bus.m_stb_o), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_err_count", 32'(bus.err_count_o), exp_errs);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      check("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rwe;
    n_tests  = 0;
    n_fail   = 0;
    exp_errs = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("reset_cyc", 32'(bus.m_cyc_o), 32'd0);
    check("reset_stb", 32'(bus.m_stb_o), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("reset_rsp_data", bus.rsp_data_o, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    check("reset_err_count", 32'(bus.err_count_o), 32'd0);
    check("reset_addr", 32'(bus.m_addr_o), 32'd0);
    check("reset_we", 32'(bus.m_we_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(4'hF, 11'h000, 32'hA5A5A5A5, 0, 1, 0, 0);
    run_txn(4'h0, 11'h000, $urandom, 0, 1, 0, 1);
    run_txn(4'hF, 11'h400, 32'hCAFEF00D, 3, 1, 0, 0);
    run_txn(4'h0, 11'h400, $urandom, 0, 0, 0, 2);
    run_txn(4'hF, 11'h005, $urandom, 0, 0, 1, 0);
    run_txn(4'h0, 11'h006, $urandom, 0, 0, 1, 1);
    run_txn(4'h0, 11'h000, $urandom, 0, TO - 1, 0, 0);
    run_txn(4'h0, 11'h000, $urandom, 0, TO, 0, 0);
    run_txn(4'hF, 11'h007, 32'h0BADBEEF, TO - 1, 0, 0, 0);
    run_txn(4'hF, 11'h008, 32'h0BADBEEF, TO, 0, 0, 0);
    run_txn(4'hF, 11'h00F, 32'h12345678, 2, 2, 0, 0);
    run_txn(4'hF, 11'h010, 32'h87654321, 1, 3, 0, 1);
    run_txn(4'h0, 11'h00F, $urandom, 2, 1, 0, 0);
    run_txn(4'h0, 11'h010, $urandom, 0, 2, 0, 0);
    run_txn(4'h5, 11'h00F, 32'hFFFFFFFF, 0, 1, 0, 0);
    run_txn(4'h0, 11'h00F, $urandom, 0, 1, 0, 0);

    reset_mid_txn();
    run_txn(4'h0, 11'h00F, $urandom, 0, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rwe = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(rwe, 11'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4),
              ($urandom_range(0, 7) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
    end

    // Drive the error counter into saturation and past it.
    while (exp_errs < 255)
      run_txn(4'h0, 11'h001, $urandom, 0, 0, 1, 0);
    run_txn(4'h0, 11'h001, $urandom, TO, 0, 1, 0);
    run_txn(4'h0, 11'h001, $urandom, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-port Wishbone pipelined initiator (bus master) that turns a valid/ready command stream into one Wishbone transaction at a time and returns the result on a valid/ready response stream. It drives one port (A or B) of the dual-port RAM arbiter top from the master side, honouring stall and ack, and bounds every transaction with a timeout. It is the reusable front end for the test engines and CPU-side glue that will sit in front of the shared RAM.

## Interface
Parameters:
- ADDR_W, 11, Wishbone word-address width (matches arbiter port).
- DATA_W, 32, data width; byte-enable width SEL_W = DATA_W/8.
- TIMEOUT, 16, cycles cyc may stay high without ack before error; legal range 2..255.

Ports:
- clk  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this edge if valid.
- cmd_we_i  in  SEL_W  byte write enables; all zero = read.
- cmd_addr_i  in  ADDR_W  target address.
- cmd_data_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes response.
- rsp_data_o  out  DATA_W  captured m_data_i (read data; write result too).
- rsp_err_o  out  1  transaction timed out.
- err_count_o  out  8  saturating timeout count.
- m_cyc_o, m_stb_o  out  1 each  Wishbone cycle / strobe.
- m_we_o  out  SEL_W  Wishbone byte write enables.
- m_addr_o  out  ADDR_W  Wishbone address.
- m_data_o  out  DATA_W  Wishbone write data.
- m_stall_i  in  1  responder not accepting request.
- m_ack_i  in  1  responder completes request.
- m_data_i  in  DATA_W  responder read data.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch we/addr/data, clear timeout counter, go REQ.
- REQ: m_cyc_o=m_stb_o=1, m_we_o/m_addr_o/m_data_o = latched values, held stable while m_stall_i=1. Request accepted at an edge with m_stall_i=0. At that edge: if m_ack_i=1, capture m_data_i, go RESP; else go WAIT.
- WAIT: m_cyc_o=1, m_stb_o=0, m_we_o held. On m_ack_i: capture m_data_i into rsp_data_o, rsp_err_o<=0, go RESP.
- Timeout: counter increments every edge in REQ/WAIT; at the edge where it equals TIMEOUT-1 with no qualifying ack, go RESP with rsp_err_o=1, rsp_data_o=0, err_count_o += 1 (saturate at 255). Ack wins over timeout on the same edge.
- RESP: rsp_valid_o=1, m_cyc_o=0; on rsp_ready_i go IDLE.
- m_we_o is 0 outside REQ/WAIT; m_addr_o/m_data_o show latched registers at all times.
- m_ack_i outside REQ/WAIT ignored; ack in REQ while stalled ignored (not an acceptance).
- One outstanding transaction; no pipelining of multiple stb.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0 except cmd_ready_o=1; latched registers, rsp_data_o, counter, err_count_o = 0. Reset mid-transaction drops m_cyc_o/m_stb_o at once; no response is produced.
- Command handshake at edge N -> m_cyc_o/m_stb_o high from cycle N+1.
- Zero stall, ack one cycle after acceptance: cyc high 2 cycles, rsp_valid_o high in cycle N+3.
- Each stalled cycle adds one cycle of stb.
- Timeout: rsp_valid_o with err rises exactly TIMEOUT cycles after m_cyc_o rises; cyc drops the same edge.
- cmd_ready_o low from REQ through RESP; minimum command-to-command spacing 3 cycles.
- rsp_data_o/rsp_err_o stable while rsp_valid_o=1 and until next response.

## Test plan
- Write 0x000 <- A5A5A5A5 (we=1111) to arbiter port A, no contention -> single stb cycle, ack, rsp_err=0; cmd_ready returns high after rsp handshake.
- Read 0x000 -> rsp_data=A5A5A5A5, m_we_o=0000 throughout.
- Model stall 3 cycles on 0x400 write -> m_stb_o high 4 cycles with address/data/we unchanged, exactly one acceptance, rsp_err=0.
- Responder never acks, TIMEOUT=16 -> rsp_valid with rsp_err=1, rsp_data=0 exactly 16 cycles after cyc rise; err_count=1; second timeout -> 2.
- Two initiators on ports A and B hitting RAM0 together (0x00F, 0x010 writes then reads) -> both complete, read back 12345678 / 87654321, stalled side keeps stb stable.
- RST_N low while in WAIT, rsp_ready held low -> cyc/stb drop immediately; after release cmd_ready=1, no rsp_valid; next read returns correct data.
